// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - time-multiplexed FIR: one multiplier, one accumulator, TAPS-deep delay line.
// Define FIR_SAT_EN to saturate the output; otherwise the shifted accumulator wraps to DATA_W bits.
module fir_serial_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [DATA_W-1:0]        i_data_in,
  input  logic                     i_coef_we,
  input  logic [$clog2(TAPS)-1:0]  i_coef_addr,
  input  logic [COEF_W-1:0]        i_coef_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        o_data_out,
  output logic                     o_busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic signed [DATA_W-1:0]   r_x [TAPS];
  logic signed [COEF_W-1:0]   r_c [TAPS];
  logic signed [ACC_W-1:0]    r_acc;
  logic [AW-1:0]              r_k;
  logic [DATA_W-1:0]          r_dout;

  logic signed [PW-1:0]       w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic [DATA_W-1:0]          w_fmt;
  logic                       w_last;
  logic                       w_coef_ok;

  assign w_last = (r_k == AW'(TAPS - 1));
  assign w_prod = r_x[r_k] * r_c[r_k];
  assign w_sum  = r_acc + {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};

  // Addresses past the last tap only exist when TAPS is not a power of two.
  generate
    if ((1 << AW) == TAPS) begin : g_pow2
      assign w_coef_ok = 1'b1;
    end else begin : g_npow2
      assign w_coef_ok = (int'(i_coef_addr) < TAPS);
    end
  endgenerate

`ifdef FIR_SAT_EN
  logic [ACC_W-OUT_SHIFT-DATA_W:0] w_top;
  assign w_top = w_sum[ACC_W-1:OUT_SHIFT+DATA_W-1];
  assign w_fmt = (&w_top || ~|w_top) ? w_sum[OUT_SHIFT +: DATA_W]
                                     : {w_sum[ACC_W-1], {(DATA_W-1){~w_sum[ACC_W-1]}}};
`else
  assign w_fmt = w_sum[OUT_SHIFT +: DATA_W];
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)  w_next = S_MAC;
      S_MAC:   if (w_last)      w_next = S_OUT;
      S_OUT:   if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_c[i] <= '0;
      end
      r_acc  <= '0;
      r_k    <= '0;
      r_dout <= '0;
    end else begin
      // Coefficients are frozen while a dot product is in flight.
      if (i_coef_we && w_coef_ok && r_state != S_MAC) begin
        r_c[i_coef_addr] <= i_coef_data;
      end
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_x[0] <= i_data_in;
            for (int i = 1; i < TAPS; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + AW'(1);
          if (w_last) begin
            r_dout <= w_fmt;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_OUT);
  assign o_busy      = (r_state != S_IDLE);
  assign o_data_out  = r_dout;

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb/tb_fir_serial_mac.sv - directed bench for fir_serial_mac with a per-cycle reference model.
module tb_fir_serial_mac;

  localparam int TAPS     = 8;
  localparam int PH_IDLE  = 0;
  localparam int PH_MAC   = 1;
  localparam int PH_OUT   = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        busy;

  fir_serial_mac dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_data_in   (data_in),
    .i_coef_we   (coef_we),
    .i_coef_addr (coef_addr),
    .i_coef_data (coef_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_data_out  (data_out),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference model: history of accepted samples, coefficient table, and
  // the result each accepted sample must produce.
  int mx [TAPS];
  int mc [TAPS];
  int ph     = PH_IDLE;
  int cnt    = 0;
  int m_exp  = 0;
  bit m_init = 1'b0;
  int dlog[$];
  int mlog[$];

  function automatic int fmt(input longint a);
    longint s;
    logic [15:0] t;
    s = a >>> 15;
`ifdef FIR_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    t = 16'(s);
    return int'($signed(t));
  endfunction

  function automatic int dot();
    longint acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(mx[k]) * longint'(mc[k]);
    return fmt(acc);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        mx[k] = 0;
        mc[k] = 0;
      end
      ph     = PH_IDLE;
      cnt    = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      case (ph)
        PH_IDLE: begin
          if (coef_we) mc[coef_addr] = int'($signed(coef_data));
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = int'($signed(data_in));
            m_exp = dot();
            ph    = PH_MAC;
            cnt   = 0;
          end
        end
        PH_MAC: begin
          cnt++;
          if (cnt == TAPS) ph = PH_OUT;
        end
        default: begin
          if (coef_we) mc[coef_addr] = int'($signed(coef_data));
          if (out_ready) begin
            mlog.push_back(m_exp);
            dlog.push_back(int'($signed(data_out)));
            ph = PH_IDLE;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready",  int'(in_ready),  int'(ph == PH_IDLE));
      chk("out_valid", int'(out_valid), int'(ph == PH_OUT));
      chk("busy",      int'(busy),      int'(ph != PH_IDLE));
      if (ph == PH_OUT) chk("data_out", int'($signed(data_out)), m_exp);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data_out",  int'(data_out),  0);
    chk("rst_busy",      int'(busy),      0);
    dlog.delete();
    mlog.delete();
  endtask

  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 3'(addr);
    coef_data = 16'(val);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic load_all(input int val);
    for (int k = 0; k < TAPS; k++) write_coef(k, val);
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("wait_out_valid");
  endtask

  task automatic send(input int v);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("wait_in_ready");
    in_valid = 1'b1;
    data_in  = 16'(v);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out();
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    chk({name, "_count"}, dlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < dlog.size(); i++) begin
      chk($sformatf("%s_dut[%0d]", name, i), dlog[i], exp[i]);
      chk($sformatf("%s_model[%0d]", name, i), mlog[i], exp[i]);
    end
  endtask

  initial begin
    int exp[$];
    int held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    do_reset();

    // Impulse response with c = 0.5
    load_all(16'h4000);
    send(1000);
    for (int i = 0; i < 9; i++) send(0);
    exp = '{500, 500, 500, 500, 500, 500, 500, 500, 0, 0};
    check_log("impulse", exp);

    // Step response
    do_reset();
    load_all(16'h4000);
    for (int i = 0; i < 10; i++) send(1000);
    exp.delete();
    for (int i = 1; i <= 10; i++) exp.push_back(i <= 8 ? 500 * i : 4000);
    check_log("step", exp);

    // Overflow at full-scale coefficients and samples
    do_reset();
    load_all(16'h7FFF);
    for (int i = 0; i < 8; i++) send(32767);
`ifdef FIR_SAT_EN
    held = 32767;
`else
    held = -16;
`endif
    chk("overflow_count", dlog.size(), 8);
    if (dlog.size() == 8) begin
      chk("overflow_dut8",   dlog[7], held);
      chk("overflow_model8", mlog[7], held);
    end

    // Backpressure: result held, inputs dropped
    do_reset();
    load_all(16'h4000);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 16'd1000;
    @(negedge clk);
    in_valid  = 1'b0;
    wait_out();
    held = int'($signed(data_out));
    chk("bp_value", held, 500);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      data_in  = 16'd7777;
      @(negedge clk);
      chk("bp_stable",   int'($signed(data_out)), held);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(in_ready),  1);
    chk("bp_release_valid", int'(out_valid), 0);
    send(0);
    exp = '{500, 500};
    check_log("bp", exp);

    // Reset in the middle of MAC clears history
    do_reset();
    load_all(16'h4000);
    send(1000);
    send(1000);
    in_valid = 1'b1;
    data_in  = 16'd1000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midmac_in_ready",  int'(in_ready),  1);
    chk("midmac_out_valid", int'(out_valid), 0);
    chk("midmac_busy",      int'(busy),      0);
    dlog.delete();
    mlog.delete();
    load_all(16'h4000);
    send(1000);
    exp = '{500};
    check_log("midmac", exp);

    // Coefficient write during MAC is ignored, in IDLE it sticks
    do_reset();
    load_all(16'h4000);
    send(1000);
    in_valid = 1'b1;
    data_in  = 16'd1000;
    @(negedge clk);
    in_valid = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'd0;
    @(negedge clk);
    coef_we = 1'b0;
    wait_out();
    @(negedge clk);
    write_coef(0, 0);
    send(1000);
    exp = '{500, 1000, 1000};
    check_log("coefwr", exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
